// File: rtl/ext_gpio_pkg.sv
// ============================================================================
// Module   : ext_gpio_pkg
// Brief    : Shared register offsets, window size and register-select enum
//            for the ext_gpio_irq_ctl GPIO controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ext_gpio_pkg;

    localparam int GPIO_WINDOW_BYTES = 32;

    localparam logic [4:0] GPIO_OFS_IN      = 5'h00;
    localparam logic [4:0] GPIO_OFS_OUT     = 5'h04;
    localparam logic [4:0] GPIO_OFS_DIR     = 5'h08;
    localparam logic [4:0] GPIO_OFS_OUT_SET = 5'h0C;
    localparam logic [4:0] GPIO_OFS_OUT_CLR = 5'h10;
    localparam logic [4:0] GPIO_OFS_RISE_EN = 5'h14;
    localparam logic [4:0] GPIO_OFS_FALL_EN = 5'h18;
    localparam logic [4:0] GPIO_OFS_STATUS  = 5'h1C;

    typedef enum logic [2:0] {
        GPIO_REG_IN,
        GPIO_REG_OUT,
        GPIO_REG_DIR,
        GPIO_REG_OUT_SET,
        GPIO_REG_OUT_CLR,
        GPIO_REG_RISE_EN,
        GPIO_REG_FALL_EN,
        GPIO_REG_STATUS
    } gpio_reg_e;

    // Maps the word index (addr[4:2]) onto a register select.
    function automatic gpio_reg_e gpio_decode(input logic [2:0] word);
        case (word)
            GPIO_OFS_IN[4:2]:      return GPIO_REG_IN;
            GPIO_OFS_OUT[4:2]:     return GPIO_REG_OUT;
            GPIO_OFS_DIR[4:2]:     return GPIO_REG_DIR;
            GPIO_OFS_OUT_SET[4:2]: return GPIO_REG_OUT_SET;
            GPIO_OFS_OUT_CLR[4:2]: return GPIO_REG_OUT_CLR;
            GPIO_OFS_RISE_EN[4:2]: return GPIO_REG_RISE_EN;
            GPIO_OFS_FALL_EN[4:2]: return GPIO_REG_FALL_EN;
            GPIO_OFS_STATUS[4:2]:  return GPIO_REG_STATUS;
            default:               return GPIO_REG_IN;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_sync_edge.sv
// ============================================================================
// Module   : gpio_sync_edge
// Brief    : Multi-stage input synchronizer; with GPIO_IRQ_EN defined also the
//            one-cycle history and enabled rise/fall edge vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_sync_edge #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
`ifdef GPIO_IRQ_EN
    input  logic [WIDTH-1:0] i_rise_en,
    input  logic [WIDTH-1:0] i_fall_en,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
`endif
    output logic [WIDTH-1:0] o_sync
);

    // w_stage[0] is the raw pin, w_stage[k] the output of flop stage k.
    logic [SYNC_STAGES:0][WIDTH-1:0] w_stage;

    assign w_stage[0] = i_async;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync_stage
        logic [WIDTH-1:0] r_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_q <= '0;
            end else begin
                r_q <= w_stage[gi];
            end
        end

        assign w_stage[gi+1] = r_q;
    end

    assign o_sync = w_stage[SYNC_STAGES];

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= o_sync;
        end
    end

    assign o_rise = o_sync & ~r_prev & i_rise_en;
    assign o_fall = ~o_sync & r_prev & i_fall_en;
`endif

endmodule

`default_nettype wire

// File: rtl/ext_gpio_irq_ctl.sv
// ============================================================================
// Module   : ext_gpio_irq_ctl
// Brief    : Memory-mapped GPIO controller with direction, atomic set/clear,
//            input synchronizer and, when GPIO_IRQ_EN is defined, per-pin
//            edge status with a level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ext_gpio_irq_ctl
    import ext_gpio_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    GPIO_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'hf000_0000,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  op,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_w,
    output logic [DATA_WIDTH-1:0] data_r,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    localparam int c_win_lsb = $clog2(GPIO_WINDOW_BYTES);

    logic                  w_hit;
    logic                  w_wr;
    logic                  w_rd;
    gpio_reg_e             w_sel;
    logic [GPIO_WIDTH-1:0] w_wdata;
    logic [GPIO_WIDTH-1:0] w_sync;
    logic [GPIO_WIDTH-1:0] w_rd_pins;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_bits;

    logic [GPIO_WIDTH-1:0] r_out;
    logic [GPIO_WIDTH-1:0] r_dir;
    logic [DATA_WIDTH-1:0] r_data_r;

    assign w_hit   = (addr[ADDR_WIDTH-1:c_win_lsb] == BASE_ADDR[ADDR_WIDTH-1:c_win_lsb]);
    assign w_sel   = gpio_decode(addr[c_win_lsb-1:2]);
    assign w_wr    = op && rw && w_hit;
    assign w_rd    = op && !rw;
    assign w_wdata = data_w[GPIO_WIDTH-1:0];

    // Byte lane bits and data bits above the pin count carry no meaning.
    assign w_unused_bits = &{1'b0, addr[1:0], data_w};

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] r_rise_en;
    logic [GPIO_WIDTH-1:0] r_fall_en;
    logic [GPIO_WIDTH-1:0] r_status;
    logic [GPIO_WIDTH-1:0] w_rise;
    logic [GPIO_WIDTH-1:0] w_fall;
    logic [GPIO_WIDTH-1:0] w_w1c;
`endif

    gpio_sync_edge #(
        .WIDTH      (GPIO_WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .i_async  (gpio_in),
`ifdef GPIO_IRQ_EN
        .i_rise_en(r_rise_en),
        .i_fall_en(r_fall_en),
        .o_rise   (w_rise),
        .o_fall   (w_fall),
`endif
        .o_sync   (w_sync)
    );

    always_comb begin
        w_rd_pins = '0;
        if (w_hit) begin
            case (w_sel)
                GPIO_REG_IN:      w_rd_pins = w_sync;
                GPIO_REG_OUT:     w_rd_pins = r_out;
                GPIO_REG_DIR:     w_rd_pins = r_dir;
`ifdef GPIO_IRQ_EN
                GPIO_REG_RISE_EN: w_rd_pins = r_rise_en;
                GPIO_REG_FALL_EN: w_rd_pins = r_fall_en;
                GPIO_REG_STATUS:  w_rd_pins = r_status;
`endif
                default:          w_rd_pins = '0;
            endcase
        end
        w_rdata                 = '0;
        w_rdata[GPIO_WIDTH-1:0] = w_rd_pins;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_out    <= '0;
            r_dir    <= '0;
            r_data_r <= '0;
        end else begin
            if (w_rd) begin
                r_data_r <= w_rdata;
            end
            if (w_wr) begin
                case (w_sel)
                    GPIO_REG_OUT:     r_out <= w_wdata;
                    GPIO_REG_DIR:     r_dir <= w_wdata;
                    GPIO_REG_OUT_SET: r_out <= r_out | w_wdata;
                    GPIO_REG_OUT_CLR: r_out <= r_out & ~w_wdata;
                    default:          ;
                endcase
            end
        end
    end

`ifdef GPIO_IRQ_EN
    assign w_w1c = (w_wr && (w_sel == GPIO_REG_STATUS)) ? w_wdata : '0;

    // New edges are OR-ed in after the clear so a same-cycle edge survives.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
        end else begin
            if (w_wr && (w_sel == GPIO_REG_RISE_EN)) begin
                r_rise_en <= w_wdata;
            end
            if (w_wr && (w_sel == GPIO_REG_FALL_EN)) begin
                r_fall_en <= w_wdata;
            end
            r_status <= (r_status & ~w_w1c) | w_rise | w_fall;
        end
    end

    assign irq = |r_status;
`else
    assign irq = 1'b0;
`endif

    assign data_r   = r_data_r;
    assign gpio_out = r_out;
    assign gpio_oe  = r_dir;

endmodule

`default_nettype wire

// File: tb/tb_ext_gpio_irq_ctl.sv
// ============================================================================
// Module   : tb_ext_gpio_irq_ctl
// Brief    : Self-checking bench for ext_gpio_irq_ctl against a register-level
//            reference model; follows GPIO_IRQ_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ext_gpio_irq_ctl;

    localparam int          SYNC_STAGES = 2;
    localparam logic [31:0] BASE        = 32'hf000_0000;
    localparam logic [31:0] A_IN        = BASE + 32'h00;
    localparam logic [31:0] A_OUT       = BASE + 32'h04;
    localparam logic [31:0] A_DIR       = BASE + 32'h08;
    localparam logic [31:0] A_SET       = BASE + 32'h0C;
    localparam logic [31:0] A_CLR       = BASE + 32'h10;
    localparam logic [31:0] A_RISE      = BASE + 32'h14;
    localparam logic [31:0] A_FALL      = BASE + 32'h18;
    localparam logic [31:0] A_STATUS    = BASE + 32'h1C;
`ifdef GPIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        op      = 1'b0;
    logic        op8     = 1'b0;
    logic        rw      = 1'b0;
    logic [31:0] addr    = '0;
    logic [31:0] data_w  = '0;
    logic [31:0] gpio_in = '0;
    logic [31:0] data_r;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        irq;
    logic [31:0] data_r8;
    logic [7:0]  gpio_out8;
    logic [7:0]  gpio_oe8;
    logic        irq8;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: architectural registers plus a queue of pin
    // samples, oldest first: [0] = previous synchronized, [1] = synchronized.
    logic [31:0] m_out, m_dir, m_re, m_fe, m_st, m_data_r;
    logic [31:0] q_in[$];

    always #5 sys_clk = ~sys_clk;

    ext_gpio_irq_ctl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .GPIO_WIDTH(32),
        .BASE_ADDR(32'hf000_0000), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .op(op), .rw(rw), .addr(addr),
        .data_w(data_w), .data_r(data_r), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    ext_gpio_irq_ctl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .GPIO_WIDTH(8),
        .BASE_ADDR(32'hf000_0000), .SYNC_STAGES(SYNC_STAGES)
    ) dut8 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .op(op8), .rw(rw), .addr(addr),
        .data_w(data_w), .data_r(data_r8), .gpio_in(gpio_in[7:0]),
        .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if ((a & ~32'h1f) != BASE) return 32'h0;
        case (a[4:2])
            3'd0:    return q_in[1];
            3'd1:    return m_out;
            3'd2:    return m_dir;
            3'd5:    return IRQ_EN ? m_re : 32'h0;
            3'd6:    return IRQ_EN ? m_fe : 32'h0;
            3'd7:    return IRQ_EN ? m_st : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [31:0] rise, fall, w1c, sync_v, prev_v;
        if (sys_rst) begin
            m_out = '0; m_dir = '0; m_re = '0; m_fe = '0; m_st = '0; m_data_r = '0;
            q_in.delete();
            for (int i = 0; i <= SYNC_STAGES; i++) q_in.push_back(32'h0);
        end else begin
            prev_v = q_in[0];
            sync_v = q_in[1];
            rise   = IRQ_EN ? (sync_v & ~prev_v & m_re) : 32'h0;
            fall   = IRQ_EN ? (~sync_v & prev_v & m_fe) : 32'h0;
            w1c    = '0;
            if (op && !rw) m_data_r = m_read(addr);
            if (op && rw && ((addr & ~32'h1f) == BASE)) begin
                case (addr[4:2])
                    3'd1: m_out = data_w;
                    3'd2: m_dir = data_w;
                    3'd3: m_out = m_out | data_w;
                    3'd4: m_out = m_out & ~data_w;
                    3'd5: if (IRQ_EN) m_re = data_w;
                    3'd6: if (IRQ_EN) m_fe = data_w;
                    3'd7: if (IRQ_EN) w1c = data_w;
                    default: ;
                endcase
            end
            m_st = (m_st & ~w1c) | rise | fall;
            void'(q_in.pop_front());
            q_in.push_back(gpio_in);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge sys_clk);
        #1;
        check("gpio_out", gpio_out, m_out);
        check("gpio_oe", gpio_oe, m_dir);
        check("irq", {31'b0, irq}, {31'b0, |m_st});
        check("data_r", data_r, m_data_r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        op = 1'b1; rw = 1'b1; addr = a; data_w = d;
        tick();
        op = 1'b0; rw = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        op = 1'b1; rw = 1'b0; addr = a;
        tick();
        op = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and basic register access
        idle(2);
        sys_rst = 1'b0;
        check("rst_out", gpio_out, 32'h0);
        check("rst_oe", gpio_oe, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_data_r", data_r, 32'h0);
        bus_write(A_OUT, 32'h1234_5678);
        check("wr_out", gpio_out, 32'h1234_5678);
        bus_write(A_DIR, 32'hffff_0000);
        check("wr_dir", gpio_oe, 32'hffff_0000);
        bus_read(A_OUT);
        check("rd_out", data_r, 32'h1234_5678);
        bus_read(A_DIR);
        check("rd_dir", data_r, 32'hffff_0000);

        // Atomic set / clear
        bus_write(A_OUT, 32'h0000_00f0);
        bus_write(A_SET, 32'h0000_000f);
        check("out_set", gpio_out, 32'h0000_00ff);
        bus_write(A_CLR, 32'h0000_0030);
        check("out_clr", gpio_out, 32'h0000_00cf);
        bus_read(A_SET);
        check("rd_wo", data_r, 32'h0);

        // Input path latency
        gpio_in = 32'ha1b2_c3d4;
        bus_read(A_IN);
        check("in_early", data_r, 32'h0);
        idle(SYNC_STAGES);
        bus_read(A_IN);
        check("in_late", data_r, 32'ha1b2_c3d4);

        // Edge interrupt
        gpio_in = 32'h2;
        idle(SYNC_STAGES + 2);
        bus_write(A_RISE, 32'h1);
        bus_write(A_FALL, 32'h2);
        gpio_in = 32'h1;
        idle(SYNC_STAGES);
        check("irq_early", {31'b0, irq}, 32'h0);
        idle(1);
        check("irq_edge", {31'b0, irq}, 32'(IRQ_EN));
        bus_read(A_STATUS);
        check("status_both", data_r, IRQ_EN ? 32'h3 : 32'h0);
        bus_write(A_STATUS, 32'h1);
        check("irq_hold", {31'b0, irq}, 32'(IRQ_EN));
        bus_read(A_STATUS);
        check("status_pin1", data_r, IRQ_EN ? 32'h2 : 32'h0);
        bus_write(A_STATUS, 32'h2);
        check("irq_clr", {31'b0, irq}, 32'h0);

        // Masked edge, then edge colliding with W1C
        gpio_in = 32'h5;
        idle(SYNC_STAGES + 2);
        bus_read(A_STATUS);
        check("masked_edge", data_r, 32'h0);
        gpio_in = 32'h4;
        idle(SYNC_STAGES + 2);
        gpio_in = 32'h5;
        idle(SYNC_STAGES);
        bus_write(A_STATUS, 32'h1);
        check("collide_irq", {31'b0, irq}, 32'(IRQ_EN));
        bus_read(A_STATUS);
        check("collide_st", data_r, IRQ_EN ? 32'h1 : 32'h0);

        // Decode miss and ignored byte lane bits
        bus_write(BASE + 32'h20, 32'hdead_beef);
        check("miss_wr", gpio_out, 32'h0000_00cf);
        bus_read(BASE + 32'h20);
        check("miss_rd", data_r, 32'h0);
        bus_read(BASE + 32'h05);
        check("rd_lane", data_r, 32'h0000_00cf);

        // Reset while a write is on the bus
        op = 1'b1; rw = 1'b1; addr = A_OUT; data_w = 32'hffff_ffff; sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0; op = 1'b0; rw = 1'b0;
        check("rst_op_out", gpio_out, 32'h0);
        check("rst_op_oe", gpio_oe, 32'h0);
        check("rst_op_irq", {31'b0, irq}, 32'h0);
        check("rst_op_data_r", data_r, 32'h0);

        // Narrow instance: bits above the pin count
        op8 = 1'b1; rw = 1'b1; addr = A_OUT; data_w = 32'hffff_ffff;
        tick();
        check("w8_out", {24'h0, gpio_out8}, 32'h0000_00ff);
        addr = A_DIR; data_w = 32'hffff_ff00;
        tick();
        check("w8_oe", {24'h0, gpio_oe8}, 32'h0);
        rw = 1'b0; addr = A_OUT;
        tick();
        check("w8_rd", data_r8, 32'h0000_00ff);
        addr = BASE + 32'h20;
        tick();
        check("w8_miss", data_r8, 32'h0);
        op8 = 1'b0;
        check("w8_irq", {31'b0, irq8}, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            sys_rst = ($urandom_range(0, 299) == 0);
            op      = $urandom_range(0, 1) == 1;
            rw      = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0)
                addr = $urandom;
            else
                addr = BASE | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            data_w = ($urandom_range(0, 3) == 0) ? 32'hffff_ffff : $urandom;
            if ($urandom_range(0, 2) == 0)
                gpio_in = gpio_in ^ (32'h1 << $urandom_range(0, 31));
            tick();
        end
        sys_rst = 1'b0; op = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ext_gpio_irq_ctl.md
# ext_gpio_irq_ctl

Parametrised memory-mapped GPIO controller, successor to the fixed 32-bit in/out GPIO controller on the peripheral bus. It adds:
- per-pin direction control;
- atomic set/clear of output bits;
- a multi-stage input synchronizer;
- per-pin rising/falling edge detection with write-1-to-clear status and a level interrupt to the core.

It sits on the same `op`/`rw`/`addr`/`data_w`/`data_r` slave bus as the other external peripherals.

## Interface
- `ADDR_WIDTH`, 32, bus address width
- `DATA_WIDTH`, 32, bus data width
- `GPIO_WIDTH`, 32, pin count, 1..`DATA_WIDTH`
- `BASE_ADDR`, 32'hf0000000, register window base, 32-byte aligned
- `SYNC_STAGES`, 2, input synchronizer depth, ≥2
- `sys_clk` in 1: single clock, all logic rising-edge.
- `sys_rst` in 1: reset, synchronous and active-high.
- `op` in 1: bus access strobe.
- `rw` in 1: 1 = write, 0 = read.
- `addr` in `ADDR_WIDTH`: byte address.
- `data_w` in `DATA_WIDTH`: write data.
- `data_r` out `DATA_WIDTH`: registered read data.
- `gpio_in` in `GPIO_WIDTH`: asynchronous pin inputs.
- `gpio_out` out `GPIO_WIDTH`: output register.
- `gpio_oe` out `GPIO_WIDTH`: per-pin output enable, 1 = drive.
- `irq` out 1: level interrupt, OR of pending status bits.

## Operation
- **Address decode:** hit when `addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]`. `addr[1:0]` is ignored.
- **Register map** (offset = `addr[4:2]*4`):
  - 0x00 IN (RO): synchronized input.
  - 0x04 OUT (RW).
  - 0x08 DIR (RW): 1 = output.
  - 0x0C OUT_SET (WO): `OUT |= data_w`.
  - 0x10 OUT_CLR (WO): `OUT &= ~data_w`.
  - 0x14 RISE_EN (RW).
  - 0x18 FALL_EN (RW).
  - 0x1C STATUS (RW1C).
- **Pin bits:** bits ≥ `GPIO_WIDTH` read 0; writes to them are ignored.
- **Unmapped accesses:** WO registers read 0. Miss or unmapped read returns 0; miss write has no effect.
- **Write:** takes effect on the edge where `op && rw`. Holding `op` high repeats the write each cycle; all registers are idempotent under repetition.
- **Read:** `data_r` loads on the edge where `op && !rw`. It holds its value otherwise, including during writes.
- **Outputs:** `gpio_out` = OUT and `gpio_oe` = DIR, both driven straight from registers.
- **Synchronizer:** `gpio_in` passes through a `SYNC_STAGES` flop chain to give `sync`. `prev` is `sync` delayed by 1 cycle.
- **Edge detect:**
  - `rise = sync & ~prev & RISE_EN`
  - `fall = ~sync & prev & FALL_EN`
  - `STATUS <= (STATUS & ~w1c) | rise | fall`
  - Set wins over a same-cycle W1C on the same bit.
- **Interrupt:** `irq = |STATUS`, combinational from the register.
- **Disabled edges:** an edge on a disabled pin never sets STATUS. Enabling a pin later does not retro-capture earlier edges.

## Timing
- **Reset:** on `sys_rst` at a clock edge, clear `data_r`, OUT, DIR, RISE_EN, FALL_EN, STATUS, sync chain and `prev` to 0. So after reset `gpio_out` = 0, `gpio_oe` = 0, `irq` = 0.
- **Reset vs. bus:** reset overrides any simultaneous `op`.
- **Read latency:** 1 cycle; `data_r` is valid after the edge sampling `op`.
- **Write to pin:** `gpio_out` and `gpio_oe` change on the same edge as the write.
- **Input to IN:** a `gpio_in` change is visible in IN after `SYNC_STAGES` edges and readable on the next read edge.
- **Input to interrupt:** `irq` rises `SYNC_STAGES`+1 edges after an enabled input change. It falls the edge after a W1C of the last pending bit, unless a new edge sets a bit in that same cycle.
- **Read during W1C:** a read of STATUS in the cycle of a W1C is not possible (single port), so no read/write collision exists.
- **Short pulses:** input pulses shorter than 1 clock may be missed; no pulse stretching.

## Configuration
- **`GPIO_IRQ_EN` defined:** edge detection, RISE_EN, FALL_EN, STATUS and `irq` are implemented as above.
- **`GPIO_IRQ_EN` undefined:**
  - the `prev` register and edge logic are not built;
  - offsets 0x14–0x1C read 0 and ignore writes;
  - `irq` is tied to 0;
  - the port list is unchanged.

## Structure
- **Shared package `ext_gpio_pkg`:**
  - register offset constants (`GPIO_OFS_IN` … `GPIO_OFS_STATUS`);
  - the window size constant (32);
  - a `gpio_reg_e` enum for the decoded register select.
- **Sub-module `gpio_sync_edge`:** parametrised by width, `SYNC_STAGES` and the `GPIO_IRQ_EN` macro. It contains the synchronizer chain, `prev`, and the `rise`/`fall` vectors. The top level contains decode, registers, read mux and STATUS.

## Test plan
- **Reset:** reset, then write 0x12345678 to OUT (0xf0000004) and 0xffff0000 to DIR (0xf0000008) -> `gpio_out` = 0x12345678 and `gpio_oe` = 0xffff0000 on the write edge; reads return the same.
- **Set/clear:** OUT = 0x000000f0; write OUT_SET 0x0000000f, then OUT_CLR 0x00000030 -> `gpio_out` = 0x000000ff, then 0x000000cf.
- **Input path:** drive `gpio_in` = 0xa1b2c3d4, then read IN (0xf0000000) within `SYNC_STAGES`-1 cycles -> old value; read again later -> 0xa1b2c3d4.
- **Edge interrupt:**
  - RISE_EN = 0x1, FALL_EN = 0x2; pulse pin0 0→1 and pin1 1→0 -> STATUS = 0x3 and `irq` = 1 exactly `SYNC_STAGES`+1 edges later;
  - W1C 0x1 -> STATUS = 0x2, `irq` stays 1;
  - W1C 0x2 -> `irq` = 0.
- **Collision and masking:**
  - an enabled edge on pin0 arriving in the same cycle as a W1C 0x1 -> STATUS bit0 remains 1;
  - an edge on a disabled pin -> no status;
  - mid-sequence `sys_rst` with `op` high -> all registers 0 and `irq` = 0.
- **Width and decode:** with `GPIO_WIDTH` = 8, write 0xffffffff to OUT -> reads 0x000000ff. Access to 0xf0000020 -> read 0, no register changes.
